alu_req_sched: RTL and testbench
================================

Name: alu_req_sched

Overview:
- Two-requester scheduler in front of the registered 40-bit ALU (select codes 00101 add, 00110 sub, 01000 mul, 01011 div).
- Arbitrates between requesters round-robin and issues one operation at a time by driving the ALU a/b/s inputs.
- Waits out the ALU latency, then returns the result on a per-requester valid/ready response channel.
- Rejects illegal opcodes and divide-by-zero without touching the ALU.

Parameters:
- W, 40, operand/result width; matches ALU.
- ALU_LAT, 1, cycles from the ALU sampling edge until alu_out is captured (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  5  requester 0 ALU select code.
- req0_a, req0_b  in  W  requester 0 operands.
- rsp0_valid  out  1  response to requester 0 valid.
- rsp0_ready  in  1  requester 0 takes response.
- rsp0_data  out  W  result.
- rsp0_err  out  1  operation rejected.
- req1_* / rsp1_*  same as requester 0, for requester 1.
- alu_a, alu_b  out  W  to ALU a, b.
- alu_s  out  5  to ALU select.
- alu_out  in  W  from ALU out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE. All outputs are 0, including alu_s=00000 (the ALU holds its output).
  - last_grant=1, so requester 0 wins the first tie.
  - Any in-flight operation is dropped with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from valid and last_grant.
  - Grant rule: only one valid wins. If both are valid, the requester != last_grant wins.
  - On accept (valid&&ready at a rising edge), op/a/b/requester id are latched and last_grant is set to the id.
  - If op is not one of {00101,00110,01000,01011}, go to RESP with err=1, data=0.
  - If op==01011 and b==0, go to RESP with err=1, data=0.
  - Otherwise go to ISSUE.
  - No accept when neither requester is valid.
- ISSUE, exactly 1 cycle:
  - alu_a/alu_b/alu_s are driven from the latched values. The ALU samples them at the closing edge.
  - Next state is WAIT with counter=ALU_LAT.
- WAIT:
  - alu_s=00000 (alu_a/alu_b held).
  - The counter decrements each cycle. In the cycle the counter==1, alu_out is registered into the response data with err=0, and the next state is RESP.
- RESP:
  - rspN_valid=1 only for the granted id. data/err are held stable until rspN_ready=1 at a rising edge.
  - On that edge: valid drops and the next state is IDLE.
  - No new request is accepted in the same cycle; the earliest next accept is the following cycle.
- Latency, accept in cycle 0:
  - Legal op: ISSUE in cycle 1, WAIT in cycles 2..1+ALU_LAT, rsp_valid from cycle 2+ALU_LAT (cycle 3 for ALU_LAT=1).
  - Rejected op: rsp_valid in cycle 1.
- Arithmetic: performed by the ALU modulo 2^W.
  - add/sub wrap.
  - mul gives the low W bits of the product.
  - div gives the truncated unsigned quotient.
  - The scheduler does not modify results.
- Requester rules:
  - op/a/b must be stable while valid && !ready; the scheduler samples only on accept.
  - A requester may deassert valid before grant without effect.
- Simultaneous events:
  - A new request arriving while busy waits; its ready stays 0.
  - rsp_ready asserted before rsp_valid has no effect.
- Reset mid-operation (any state): immediate return to the reset values above.

Optional Feature:
- Macro ALU_REQ_SCHED_STATS_EN.
- When defined, adds outputs stat_ops0[15:0], stat_ops1[15:0] and stat_err[15:0]:
  - stat_ops0/stat_ops1 increment on each completed response handshake for requesters 0/1.
  - stat_err increments on each handshake with err=1.
  - All counters saturate at 0xFFFF and are cleared by rst_n.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Add: req0 op=00101 a=0x000000000B b=0x0000000003, rsp0_ready=1 -> rsp0_valid 3 cycles after accept, rsp0_data=0x000000000E, err=0.
- Sub wrap: req1 op=00110 a=0x03 b=0x0B -> rsp1_data=0xFFFFFFFFF8. Then mul 0x0B*0x03 -> 0x21. Then div 0x0B/0x03 -> 0x03.
- Errors: op=00111 -> rsp_err=1, data=0, alu_s stays 00000 throughout. Op=01011 with b=0 -> err=1, response 1 cycle after accept.
- Round-robin: both requesters valid continuously from reset with adds -> grants alternate 0,1,0,1. Each response goes only to its own channel.
- Backpressure: hold rsp0_ready=0 for 10 cycles -> rsp0_valid/data stable, req1_ready=0, busy=1. Release -> IDLE, then req1 accepted next cycle.
- Reset mid-op: drop rst_n during WAIT -> all outputs 0 immediately, no response after release. With ALU_REQ_SCHED_STATS_EN, counters read 0.

Source files
------------

// File: rtl/alu_req_sched_if.sv
// alu_req_sched_if: request/response channels for the two requesters of alu_req_sched.
// master = requester side, slave = scheduler side.
interface alu_req_sched_if #(
    parameter int W = 40
);
    logic         req0_valid;
    logic         req0_ready;
    logic [4:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [W-1:0] rsp0_data;
    logic         rsp0_err;

    logic         req1_valid;
    logic         req1_ready;
    logic [4:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp1_data;
    logic         rsp1_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err
    );
endinterface

// File: rtl/alu_req_sched.sv
// alu_req_sched: two-requester round-robin scheduler in front of a registered ALU.
// Issues one operation at a time, waits ALU_LAT cycles, returns the result on the
// requester's response channel. Illegal opcodes and divide-by-zero are answered
// with err=1 without driving the ALU select.
// Optional macro ALU_REQ_SCHED_STATS_EN adds saturating handshake counters.
module alu_req_sched #(
    parameter int W       = 40,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_req_sched_if.slave bus,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [4:0]     alu_s,
    input  logic [W-1:0]   alu_out,
`ifdef ALU_REQ_SCHED_STATS_EN
    output logic [15:0]    stat_ops0,
    output logic [15:0]    stat_ops1,
    output logic [15:0]    stat_err,
`endif
    output logic           busy
);

    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;
    localparam int         CW     = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic           last_grant;
    logic           id_q;
    logic [4:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   data_q;
    logic           err_q;

    logic           grant0, grant1, accept, reject, rsp_hs;
    logic [4:0]     sel_op;
    logic [W-1:0]   sel_a, sel_b;

    // Round-robin grant, selected request fields and accept/reject decode
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        sel_op = grant1 ? bus.req1_op : bus.req0_op;
        sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
        sel_b  = grant1 ? bus.req1_b  : bus.req0_b;
        reject = !((sel_op == OP_ADD) || (sel_op == OP_SUB) ||
                   (sel_op == OP_MUL) || (sel_op == OP_DIV)) ||
                 ((sel_op == OP_DIV) && (sel_b == '0));
        accept = (state == IDLE) && (grant0 || grant1);
        rsp_hs = (state == RESP) && (id_q ? bus.rsp1_ready : bus.rsp0_ready);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_data  = '0;
        bus.rsp1_data  = '0;
        bus.rsp0_err   = 1'b0;
        bus.rsp1_err   = 1'b0;
        alu_a          = a_q;
        alu_b          = b_q;
        alu_s          = '0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                bus.req0_ready = grant0;
                bus.req1_ready = grant1;
                if (accept) state_nxt = reject ? RESP : ISSUE;
            end
            ISSUE: begin
                alu_s     = op_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) state_nxt = RESP;
            end
            RESP: begin
                if (id_q) begin
                    bus.rsp1_valid = 1'b1;
                    bus.rsp1_data  = data_q;
                    bus.rsp1_err   = err_q;
                end else begin
                    bus.rsp0_valid = 1'b1;
                    bus.rsp0_data  = data_q;
                    bus.rsp0_err   = err_q;
                end
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, latency counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q       <= grant1;
                        last_grant <= grant1;
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        if (reject) begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= CW'(ALU_LAT);
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        data_q <= alu_out;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_REQ_SCHED_STATS_EN
    // Saturating counts of completed response handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_err  <= '0;
        end else if (rsp_hs) begin
            if (!id_q && (stat_ops0 != '1)) stat_ops0 <= stat_ops0 + 16'd1;
            if (id_q && (stat_ops1 != '1))  stat_ops1 <= stat_ops1 + 16'd1;
            if (err_q && (stat_err != '1))  stat_err  <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched: scoreboard bench for alu_req_sched with a behavioural registered ALU.
`timescale 1ns/1ps
module tb_alu_req_sched;
    localparam int W       = 40;
    localparam int ALU_LAT = 1;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] alu_a, alu_b;
    logic [W-1:0] alu_out = '0;
    logic [4:0]   alu_s;
    logic         busy;
`ifdef ALU_REQ_SCHED_STATS_EN
    logic [15:0]  stat_ops0, stat_ops1, stat_err;
`endif

    int   checks = 0;
    int   errors = 0;
    int   alu_sel_cnt = 0;
    rsp_t q0[$];
    rsp_t q1[$];

    alu_req_sched_if #(.W(W)) bus ();

    alu_req_sched #(.W(W), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_out   (alu_out),
`ifdef ALU_REQ_SCHED_STATS_EN
        .stat_ops0 (stat_ops0),
        .stat_ops1 (stat_ops1),
        .stat_err  (stat_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered ALU: latches a result only for a known select, otherwise holds
    always @(posedge clk) begin
        case (alu_s)
            OP_ADD: alu_out <= alu_a + alu_b;
            OP_SUB: alu_out <= alu_a - alu_b;
            OP_MUL: alu_out <= alu_a * alu_b;
            OP_DIV: alu_out <= (alu_b != '0) ? alu_a / alu_b : '0;
            default: ;
        endcase
    end

    // Counts cycles in which the scheduler drives a non-zero ALU select
    always @(negedge clk) if (alu_s != 5'b00000) alu_sel_cnt <= alu_sel_cnt + 1;

    function automatic rsp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        rsp_t r;
        r.err  = 1'b0;
        r.data = '0;
        case (op)
            OP_ADD: r.data = a + b;
            OP_SUB: r.data = a - b;
            OP_MUL: r.data = a * b;
            OP_DIV: if (b == '0) r.err = 1'b1; else r.data = a / b;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and waits (bounded) for its accept edge; returns 1 cycle after accept.
    task automatic issue(input int id, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output bit acc);
        acc = 1'b0;
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            if ((id == 0) ? bus.req0_ready : bus.req1_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    // Waits (bounded) for a response; lat counts cycles after the accept edge, starting at 1.
    task automatic await_rsp(input int id, output bit got, output int lat, output rsp_t r);
        got = 1'b0;
        lat = 1;
        r   = '0;
        for (int i = 0; i < 50; i++) begin
            if ((id == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                got    = 1'b1;
                r.err  = (id == 0) ? bus.rsp0_err  : bus.rsp1_err;
                r.data = (id == 0) ? bus.rsp0_data : bus.rsp1_data;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [4*W+11:0] v;
        rst_n = 1'b0;
        repeat (3) tick();
        v = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err,
             bus.rsp1_err, bus.rsp0_data, bus.rsp1_data, alu_a, alu_b, alu_s, busy};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", v);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_add();
        bit   acc, got;
        int   lat, sel0;
        rsp_t r, e;
        sel0 = alu_sel_cnt;
        q0.push_back('{err: 1'b0, data: 40'h000000000E});
        issue(0, OP_ADD, 40'h000000000B, 40'h0000000003, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL add_accept got 0 exp 1"); end
        await_rsp(0, got, lat, r);
        e = q0.pop_front();
        checks++;
        if (!got || lat !== 3) begin
            errors++; $display("FAIL add_latency got %0d (valid %0b) exp 3", lat, got);
        end
        checks++;
        if (r !== e) begin
            errors++; $display("FAIL add_data got err=%b data=%h exp err=%b data=%h", r.err, r.data, e.err, e.data);
        end
        tick();
        checks++;
        if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL add_release got valid=%b busy=%b exp 0 0", bus.rsp0_valid, busy);
        end
        checks++;
        if (alu_sel_cnt - sel0 !== 1) begin
            errors++; $display("FAIL add_issue_cycles got %0d exp 1", alu_sel_cnt - sel0);
        end
    endtask

    task automatic test_arith();
        logic [4:0]   ops [3] = '{OP_SUB, OP_MUL, OP_DIV};
        logic [W-1:0] as  [3] = '{40'h03, 40'h0B, 40'h0B};
        logic [W-1:0] bs  [3] = '{40'h0B, 40'h03, 40'h03};
        logic [W-1:0] xs  [3] = '{40'hFFFFFFFFF8, 40'h21, 40'h03};
        bit   acc, got;
        int   lat;
        rsp_t r, e;
        for (int k = 0; k < 3; k++) begin
            q1.push_back('{err: 1'b0, data: xs[k]});
            issue(1, ops[k], as[k], bs[k], acc);
            await_rsp(1, got, lat, r);
            e = q1.pop_front();
            checks++;
            if (!acc || !got || lat !== 3) begin
                errors++; $display("FAIL arith_%0d_timing got acc=%b valid=%b lat=%0d exp 1 1 3", k, acc, got, lat);
            end
            checks++;
            if (r !== e) begin
                errors++; $display("FAIL arith_%0d_data got err=%b data=%h exp err=%b data=%h", k, r.err, r.data, e.err, e.data);
            end
            tick();
        end
    endtask

    task automatic test_errors();
        bit   acc, got;
        int   lat, sel0;
        rsp_t r, e;
        sel0 = alu_sel_cnt;
        q0.push_back('{err: 1'b1, data: '0});
        issue(0, 5'b00111, 40'h5, 40'h6, acc);
        await_rsp(0, got, lat, r);
        e = q0.pop_front();
        checks++;
        if (!acc || !got || lat !== 1) begin
            errors++; $display("FAIL illegal_timing got acc=%b valid=%b lat=%0d exp 1 1 1", acc, got, lat);
        end
        checks++;
        if (r !== e) begin
            errors++; $display("FAIL illegal_rsp got err=%b data=%h exp err=%b data=%h", r.err, r.data, e.err, e.data);
        end
        tick();
        q1.push_back('{err: 1'b1, data: '0});
        issue(1, OP_DIV, 40'h1234, 40'h0, acc);
        await_rsp(1, got, lat, r);
        e = q1.pop_front();
        checks++;
        if (!acc || !got || lat !== 1) begin
            errors++; $display("FAIL div0_timing got acc=%b valid=%b lat=%0d exp 1 1 1", acc, got, lat);
        end
        checks++;
        if (r !== e) begin
            errors++; $display("FAIL div0_rsp got err=%b data=%h exp err=%b data=%h", r.err, r.data, e.err, e.data);
        end
        tick();
        checks++;
        if (alu_sel_cnt !== sel0) begin
            errors++; $display("FAIL reject_alu_untouched got %0d exp %0d", alu_sel_cnt - sel0, 0);
        end
    endtask

`ifdef ALU_REQ_SCHED_STATS_EN
    task automatic test_stats(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] ee);
        checks++;
        if (stat_ops0 !== e0 || stat_ops1 !== e1 || stat_err !== ee) begin
            errors++;
            $display("FAIL stats got %0d %0d %0d exp %0d %0d %0d", stat_ops0, stat_ops1, stat_err, e0, e1, ee);
        end
    endtask
`endif

    task automatic test_round_robin();
        int           order[$];
        int           nrsp;
        bit           acc0, acc1;
        logic [W-1:0] a0, a1;
        rsp_t         e;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a0 = 40'h10;
        a1 = 40'hFFFFFFFFFE;
        nrsp = 0;
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = a0; bus.req0_b = 40'h1;
        bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = a1; bus.req1_b = 40'h5;
        for (int c = 0; c < 100 && nrsp < 4; c++) begin
            #1;
            acc0 = bus.req0_ready;
            acc1 = bus.req1_ready;
            if (acc0 && acc1) begin
                checks++; errors++; $display("FAIL rr_both_ready got 11 exp one-hot");
            end
            if (acc0) begin order.push_back(0); q0.push_back(model(OP_ADD, a0, 40'h1)); end
            if (acc1) begin order.push_back(1); q1.push_back(model(OP_ADD, a1, 40'h5)); end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                nrsp++;
                checks++;
                if (bus.rsp0_valid && bus.rsp1_valid) begin
                    errors++; $display("FAIL rr_both_valid got 11 exp one-hot");
                end else if (bus.rsp0_valid) begin
                    if (q0.size() == 0) begin
                        errors++; $display("FAIL rr_rsp0_unexpected got data=%h exp none", bus.rsp0_data);
                    end else begin
                        e = q0.pop_front();
                        if ({bus.rsp0_err, bus.rsp0_data} !== e) begin
                            errors++; $display("FAIL rr_rsp0 got %h exp %h", {bus.rsp0_err, bus.rsp0_data}, e);
                        end
                    end
                end else begin
                    if (q1.size() == 0) begin
                        errors++; $display("FAIL rr_rsp1_unexpected got data=%h exp none", bus.rsp1_data);
                    end else begin
                        e = q1.pop_front();
                        if ({bus.rsp1_err, bus.rsp1_data} !== e) begin
                            errors++; $display("FAIL rr_rsp1 got %h exp %h", {bus.rsp1_err, bus.rsp1_data}, e);
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            if (acc0) begin a0 = a0 + 40'h7; bus.req0_a = a0; end
            if (acc1) begin a1 = a1 + 40'h3; bus.req1_a = a1; end
            if (order.size() >= 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
        end
        checks++;
        if (nrsp !== 4 || order.size() !== 4) begin
            errors++; $display("FAIL rr_count got grants=%0d rsps=%0d exp 4 4", order.size(), nrsp);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (order[k] !== (k % 2)) begin
                    errors++; $display("FAIL rr_order_%0d got %0d exp %0d", k, order[k], k % 2);
                end
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        q0.delete();
        q1.delete();
        tick();
    endtask

    task automatic test_backpressure();
        bit   acc, got;
        int   lat;
        rsp_t r, e;
        bus.rsp0_ready = 1'b0;
        q0.push_back('{err: 1'b0, data: 40'h0F});
        issue(0, OP_ADD, 40'h7, 40'h8, acc);
        await_rsp(0, got, lat, r);
        e = q0.pop_front();
        checks++;
        if (!acc || !got || r !== e) begin
            errors++; $display("FAIL bp_first got acc=%b valid=%b data=%h exp 1 1 %h", acc, got, r.data, e.data);
        end
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 40'h10; bus.req1_b = 40'h1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 40'h0F || bus.req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid=%b data=%h r1rdy=%b busy=%b exp 1 0f 0 1", c,
                         bus.rsp0_valid, bus.rsp0_data, bus.req1_ready, busy);
            end
            @(posedge clk);
            #1;
        end
        bus.rsp0_ready = 1'b1;
        q1.push_back('{err: 1'b0, data: 40'h0F});
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || bus.req1_ready !== 1'b1 || bus.rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got busy=%b r1rdy=%b v0=%b exp 0 1 0", busy, bus.req1_ready, bus.rsp0_valid);
        end
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL bp_accept1 busy got %b exp 1", busy);
        end
        await_rsp(1, got, lat, r);
        e = q1.pop_front();
        checks++;
        if (!got || lat !== 3 || r !== e) begin
            errors++; $display("FAIL bp_req1 got valid=%b lat=%0d data=%h exp 1 3 %h", got, lat, r.data, e.data);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        bit              acc;
        int              seen;
        logic [4*W+11:0] v;
        issue(0, OP_MUL, 40'h1234, 40'h5678, acc);
        tick();
        checks++;
        if (!acc || busy !== 1'b1 || alu_s !== 5'b00000) begin
            errors++; $display("FAIL midrst_wait got acc=%b busy=%b alu_s=%b exp 1 1 00000", acc, busy, alu_s);
        end
        rst_n = 1'b0;
        #1;
        v = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err,
             bus.rsp1_err, bus.rsp0_data, bus.rsp1_data, alu_a, alu_b, alu_s, busy};
        checks++;
        if (v !== '0) begin
            errors++; $display("FAIL midrst_outputs got %h exp 0", v);
        end
`ifdef ALU_REQ_SCHED_STATS_EN
        test_stats(16'd0, 16'd0, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rsp0_valid || bus.rsp1_valid || busy) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midrst_no_rsp got %0d active cycles exp 0", seen);
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ready = 1'b1;
        #1;
        test_reset();
        test_add();
        test_arith();
        test_errors();
`ifdef ALU_REQ_SCHED_STATS_EN
        test_stats(16'd2, 16'd4, 16'd2);
`endif
        test_round_robin();
        test_backpressure();
`ifdef ALU_REQ_SCHED_STATS_EN
        test_stats(16'd3, 16'd3, 16'd0);
`endif
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
